// File: rtl/sigmoid_pkg.sv
// Shared widths, breakpoints and offsets for the PLAN piecewise-linear sigmoid.
// Used by sigmoid_plan_core and sigmoid_unit.
package sigmoid_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int ACC_W = 9;

  localparam logic [IN_W-1:0]  BP1  = 8'd16;
  localparam logic [IN_W-1:0]  BP2  = 8'd38;
  localparam logic [IN_W-1:0]  BP3  = 8'd80;

  localparam logic [ACC_W-1:0] OFF0 = 9'd128;
  localparam logic [ACC_W-1:0] OFF1 = 9'd160;
  localparam logic [ACC_W-1:0] OFF2 = 9'd216;
  localparam logic [ACC_W-1:0] SAT  = 9'd256;

  typedef enum logic [1:0] {
    SEG0,
    SEG1,
    SEG2,
    SEG_SAT
  } seg_e;

  function automatic seg_e seg_of(input logic [IN_W-1:0] mag);
    if (mag < BP1)      return SEG0;
    else if (mag < BP2) return SEG1;
    else if (mag < BP3) return SEG2;
    else                return SEG_SAT;
  endfunction

endpackage

// File: rtl/sigmoid_plan_core.sv
// Combinational PLAN sigmoid: |x|, segment select, segment evaluation and the
// negative-side mirror (out = 1 - p).
module sigmoid_plan_core
  import sigmoid_pkg::*;
(
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  logic [IN_W-1:0]  mag;
  logic [ACC_W-1:0] p;
  seg_e             seg;

  always_comb begin
    // 0x80 negates to itself, which reads as 128 unsigned.
    mag = in[IN_W-1] ? IN_W'(~in + 8'd1) : in;
    seg = seg_of(mag);
    case (seg)
      SEG0:    p = OFF0 + (ACC_W'(mag) << 2);
      SEG1:    p = OFF1 + (ACC_W'(mag) << 1);
      SEG2:    p = OFF2 + ACC_W'(mag >> 1);
      default: p = SAT;
    endcase
    // p never drops below 128, so the mirrored value always fits in OUT_W bits.
    if (in[IN_W-1])
      out = OUT_W'(SAT - p);
    else
      out = p[ACC_W-1] ? {OUT_W{1'b1}} : p[OUT_W-1:0];
  end

endmodule

// File: rtl/sigmoid_unit.sv
// Registered sigmoid activation with valid flag. Define SIGMOID_OUT_REG_EN to
// add a second data/valid register stage (2-cycle latency).
module sigmoid_unit
  import sigmoid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] f_value;
  logic [OUT_W-1:0] s1_data_reg;
  logic             s1_valid_reg;

  sigmoid_plan_core u_core (
    .in  (in),
    .out (f_value)
  );

  // Data only loads on valid, so the last result holds while valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid)
        s1_data_reg <= f_value;
    end
  end

`ifdef SIGMOID_OUT_REG_EN
  logic [OUT_W-1:0] s2_data_reg;
  logic             s2_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg)
        s2_data_reg <= s1_data_reg;
    end
  end

  assign out       = s2_data_reg;
  assign out_valid = s2_valid_reg;
`else
  assign out       = s1_data_reg;
  assign out_valid = s1_valid_reg;
`endif

endmodule

// File: tb/tb_sigmoid_unit.sv
// Scoreboard bench for sigmoid_unit: directed vectors, hold/drop, reset cases,
// full 256-input sweep and monotonicity. Honours SIGMOID_OUT_REG_EN.
module tb_sigmoid_unit;

`ifdef SIGMOID_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
    int         cyc;
    int         tag;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] din;
  logic       out_valid;
  logic [7:0] dout;

  sb_item_t   sb[$];
  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] sweep_res [256];

  sigmoid_unit dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int required);
    total_cnt++;
    if (actual == required) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, required);
  endtask

  // Reference straight from the segment formula.
  function automatic logic [7:0] model(input logic [7:0] v);
    int a, p;
    a = v[7] ? 256 - int'(v) : int'(v);
    if (a < 16)      p = 128 + 4 * a;
    else if (a < 38) p = 160 + 2 * a;
    else if (a < 80) p = 216 + a / 2;
    else             p = 256;
    if (v[7]) return 8'(256 - p);
    return (p > 255) ? 8'd255 : 8'(p);
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got out=%0d with empty scoreboard at cycle %0d", dout, cyc);
      end else begin
        sb_item_t e;
        e = sb.pop_front();
        check($sformatf("value in=0x%02h", e.din), int'(dout), int'(e.exp));
        check($sformatf("latency in=0x%02h", e.din), cyc, e.cyc);
        if (e.tag >= 0) sweep_res[e.tag] = dout;
        $display("txn in=0x%02h out=%0d exp=%0d cycle=%0d", e.din, dout, e.exp, cyc);
      end
    end
  end

  // Drive one sample at a negedge; it is captured on the next posedge.
  task automatic send(input logic [7:0] v, input logic [7:0] exp, input int tag, input bit track);
    din      = v;
    in_valid = 1'b1;
    if (track) sb.push_back('{din: v, exp: exp, cyc: cyc + LAT, tag: tag});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] bp_in  [7] = '{8'h0F, 8'h10, 8'h25, 8'h26, 8'h4F, 8'h50, 8'h7F};
  logic [7:0] bp_exp [7] = '{8'd188, 8'd192, 8'd234, 8'd235, 8'd255, 8'd255, 8'd255};
  logic [7:0] ng_in  [5] = '{8'hF0, 8'hDA, 8'hB0, 8'h80, 8'hFF};
  logic [7:0] ng_exp [5] = '{8'd64, 8'd21, 8'd0, 8'd0, 8'd124};

  initial begin
    for (int i = 0; i < 256; i++) sweep_res[i] = 8'd0;
    reset    = 1'b1;
    in_valid = 1'b1;
    din      = 8'h7F;
    repeat (2) @(negedge clk);
    check("reset out", int'(dout), 0);
    check("reset out_valid", int'(out_valid), 0);

    reset = 1'b0;
    send(8'h00, 8'd128, -1, 1'b1);
    idle(LAT + 1);

    for (int i = 0; i < 7; i++) send(bp_in[i], bp_exp[i], -1, 1'b1);
    for (int i = 0; i < 5; i++) send(ng_in[i], ng_exp[i], -1, 1'b1);
    idle(LAT + 1);

    // Hold/drop: result stays put and valid stays low once input goes idle.
    send(8'h10, 8'd192, -1, 1'b1);
    in_valid = 1'b0;
    din      = 8'h80;
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold out k=%0d", k), int'(dout), 192);
      check($sformatf("hold out_valid k=%0d", k), int'(out_valid), 0);
      @(negedge clk);
    end

    // Reset mid-stream: 0x20 meets reset on its capture edge.
    send(8'h10, 8'd192, -1, LAT == 1);
    din      = 8'h20;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    check("midreset out", int'(dout), 0);
    check("midreset out_valid", int'(out_valid), 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      check("postreset out_valid", int'(out_valid), 0);
    end

    // Sweep in signed order: -128 .. +127.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i + 128);
      send(v, model(v), i, 1'b1);
    end
    idle(LAT + 2);
    check("drain pending", sb.size(), 0);

    for (int i = 1; i < 256; i++) begin
      if (sweep_res[i] < sweep_res[i-1]) begin
        total_cnt++;
        $display("FAIL monotonic idx=%0d: got %0d after %0d, required >= previous",
                 i, sweep_res[i], sweep_res[i-1]);
      end else begin
        total_cnt++;
        pass_cnt++;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sigmoid_unit.md
# sigmoid_unit

Fixed-point logistic activation for the XOR neural-network datapath; one instance sits after each hidden-layer and output-layer pre-activation sum. It maps a signed Q4.4 pre-activation to an unsigned Q0.8 activation using the four-segment PLAN piecewise-linear approximation, mirrored for negative inputs. The output is registered, with a valid flag travelling alongside the data.

## Interface
- No parameters; widths are fixed by `sigmoid_pkg`.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in` carries a new sample this cycle.
- `in`  in  8  pre-activation, signed two's complement Q4.4, range −8.0 to +7.9375.
- `out_valid`  out  1  `out` holds a fresh result.
- `out`  out  8  activation, unsigned Q0.8 (value/256).

## Operation
- a = |in| in 1/16 units, 8 bits unsigned; `in`=0x80 gives a=128.
- Positive segment value p (9 bits, units of 1/256), integer arithmetic, floor division:
  - a < 16: p = 128 + 4a
  - 16 ≤ a < 38: p = 160 + 2a
  - 38 ≤ a < 80: p = 216 + (a >> 1)
  - a ≥ 80: p = 256
- in[7]=0: out = min(p, 255).
- in[7]=1: out = 256 − p, which gives 0 for a ≥ 80.
- Zero input is non-negative: `in`=0x00 gives 128.
- No other rounding, no dither. Results are monotonic non-decreasing over signed input order.

## Timing
- Base latency is 1 cycle. On the rising edge where `in_valid`=1, `out` is loaded with f(`in`) and `out_valid` is set to 1.
- On a rising edge with `in_valid`=0:
  - `out` holds its last value.
  - `out_valid` drops to 0.
- Back-to-back samples are accepted every cycle, giving a throughput of 1 sample per cycle.
- There is no back-pressure; the consumer must take the result in the cycle `out_valid` is high.
- Reset: on a rising edge with `reset`=1, every register clears (`out`=0x00, `out_valid`=0).
  - `reset` takes priority over `in_valid` on the same edge.
  - Asserting `reset` mid-stream discards any in-flight sample; no `out_valid` pulse is produced for it.
- The first valid result appears 1 cycle after the first accepted sample following reset deassertion.

## Configuration
- `SIGMOID_OUT_REG_EN` defined:
  - A second register stage (data plus valid) is added after the first.
  - Latency becomes 2 cycles; throughput is unchanged.
  - Both stages clear on reset.
  - Hold/drop rules apply at the final stage, with `in_valid` delayed one cycle.
- `SIGMOID_OUT_REG_EN` undefined: single stage, 1-cycle latency.

## Structure
- Shared package `sigmoid_pkg`:
  - width constants: IN_W=8, OUT_W=8, ACC_W=9
  - breakpoints: BP1=16, BP2=38, BP3=80
  - segment offsets: OFF0=128, OFF1=160, OFF2=216
  - saturation value: SAT=256
- One combinational sub-module, `sigmoid_plan_core`, covers the absolute value, segment select, segment evaluation and negative mirror.
- `sigmoid_unit` wraps `sigmoid_plan_core` with the valid/reset register stage(s).

## Test plan
- Reset then sample: `reset` high 2 cycles, then `in`=0x00 with `in_valid`=1 → next cycle `out`=128, `out_valid`=1; during reset `out`=0, `out_valid`=0.
- Segment breakpoints, streamed one per cycle with `in_valid` high: `in`=0x0F→188, 0x10→192, 0x25→234, 0x26→235, 0x4F→255, 0x50→255, 0x7F→255; results appear in order, 1 cycle later.
- Negative mirror: `in`=0xF0 (−1.0)→64, 0xDA (−38/16)→21, 0xB0 (−5.0)→0, 0x80→0, 0xFF→124.
- Hold/drop: after `in`=0x10 is accepted, hold `in_valid`=0 and change `in` to 0x80 → `out` stays 192 and `out_valid`=0 on every following cycle.
- Reset mid-stream: stream 0x10, 0x20, assert `reset` on the edge that would capture 0x20 → `out`=0, `out_valid`=0, no result for 0x20.
- With `SIGMOID_OUT_REG_EN`: repeat the breakpoint stream → identical values, each arriving 2 cycles after capture; exhaustive sweep of all 256 inputs against the segment formula, plus a monotonicity check.
